// File: rtl/ins_fetcher_pkg.sv
// Shared widths, opcodes, FSM encoding and queue entry layout for the fetch stage.
package ins_fetcher_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int INS_WIDTH  = 32;

  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

  localparam logic [1:0] ST_ENC_REQ       = 2'd0;
  localparam logic [1:0] ST_ENC_RESTART   = 2'd1;
  localparam logic [1:0] ST_ENC_HOLD_JALR = 2'd2;

  typedef enum logic [1:0] {
    ST_REQ     = ST_ENC_REQ,
    ST_RESTART = ST_ENC_RESTART
`ifdef INS_FETCHER_JALR_STALL_EN
    , ST_HOLD_JALR = ST_ENC_HOLD_JALR
`endif
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INS_WIDTH-1:0]  ins;
    logic                  pred_jump;
  } iq_entry_t;

  function automatic logic is_jalr(input logic [INS_WIDTH-1:0] ins);
    return (ins[6:0] == OPCODE_JALR);
  endfunction

endpackage

// File: rtl/ins_fetcher_if.sv
// Fetch-stage bus: ICache request/response, predictor, dispatcher and ROB flush.
interface ins_fetcher_if;
  import ins_fetcher_pkg::*;

  logic                  fetch_valid;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  icache_hit;
  logic [INS_WIDTH-1:0]  icache_ins;
  logic [ADDR_WIDTH-1:0] pc_cur;
  logic [INS_WIDTH-1:0]  ins_cur;
  logic [ADDR_WIDTH-1:0] pc_pred;
  logic                  predict_jump;
  logic                  ins_valid;
  logic [INS_WIDTH-1:0]  ins_out;
  logic [ADDR_WIDTH-1:0] ins_pc;
  logic                  ins_pred_jump;
  logic                  dispatch_ready;
  logic                  rob_clear;
  logic [ADDR_WIDTH-1:0] rob_redirect_pc;

  modport master (
    output fetch_valid, fetch_addr, pc_cur, ins_cur,
           ins_valid, ins_out, ins_pc, ins_pred_jump,
    input  icache_hit, icache_ins, pc_pred, predict_jump,
           dispatch_ready, rob_clear, rob_redirect_pc
  );

  modport slave (
    input  fetch_valid, fetch_addr, pc_cur, ins_cur,
           ins_valid, ins_out, ins_pc, ins_pred_jump,
    output icache_hit, icache_ins, pc_pred, predict_jump,
           dispatch_ready, rob_clear, rob_redirect_pc
  );

endinterface

// File: rtl/ins_fetcher_queue.sv
// Synchronous FIFO (module ins_queue) with clear; push/pop are ignored when full/empty.
module ins_queue #(
  parameter int DEPTH_LOG = 4,
  parameter int WIDTH     = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG-1:0] PTR_ONE = DEPTH_LOG'(1);
  localparam logic [DEPTH_LOG:0]   CNT_ONE = (DEPTH_LOG+1)'(1);

  logic [WIDTH-1:0]     mem_r [DEPTH];
  logic [DEPTH_LOG-1:0] head_r;
  logic [DEPTH_LOG-1:0] tail_r;
  logic [DEPTH_LOG:0]   count_r;
  logic                 push_ok_s;
  logic                 pop_ok_s;

  assign full      = count_r[DEPTH_LOG];
  assign empty     = (count_r == {(DEPTH_LOG+1){1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign head      = mem_r[head_r];

  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (push_ok_s && !rst && !clear) begin
      mem_r[tail_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head_r  <= {DEPTH_LOG{1'b0}};
      tail_r  <= {DEPTH_LOG{1'b0}};
      count_r <= {(DEPTH_LOG+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/ins_fetcher.sv
// Fetch stage: owns the fetch PC and FSM, feeds the instruction queue.
// Optional JALR stall is enabled by defining INS_FETCHER_JALR_STALL_EN.
module ins_fetcher
  import ins_fetcher_pkg::*;
#(
  parameter int                    IQ_SIZE_LOG = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  ins_fetcher_if.master  bus
);

  fetch_state_e          state_r;
  fetch_state_e          state_n_s;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [ADDR_WIDTH-1:0] pc_n_s;
  logic                  fetch_valid_s;
  logic                  hit_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  clear_s;
  logic                  full_s;
  logic                  empty_s;
  iq_entry_t             push_entry_s;
  iq_entry_t             head_entry_s;
  logic [$bits(iq_entry_t)-1:0] head_data_s;

  assign fetch_valid_s = !rst && (state_r == ST_REQ) && !full_s;
  assign hit_s         = fetch_valid_s && bus.icache_hit;
  // A flush discards any same-cycle hit and pop
  assign push_s        = rdy && !bus.rob_clear && hit_s;
  assign pop_s         = rdy && !bus.rob_clear && bus.dispatch_ready;
  assign clear_s       = rdy && bus.rob_clear;

  assign bus.fetch_valid   = fetch_valid_s;
  assign bus.fetch_addr    = pc_r;
  assign bus.pc_cur        = pc_r;
  assign bus.ins_cur       = bus.icache_ins;
  assign head_entry_s      = iq_entry_t'(head_data_s);
  assign bus.ins_valid     = !empty_s;
  assign bus.ins_out       = head_entry_s.ins;
  assign bus.ins_pc        = head_entry_s.pc;
  assign bus.ins_pred_jump = head_entry_s.pred_jump;

  // Entry pushed on a hit
  always_comb begin
    push_entry_s.pc  = pc_r;
    push_entry_s.ins = bus.icache_ins;
`ifdef INS_FETCHER_JALR_STALL_EN
    push_entry_s.pred_jump = is_jalr(bus.icache_ins) ? 1'b0 : bus.predict_jump;
`else
    push_entry_s.pred_jump = bus.predict_jump;
`endif
  end

  ins_queue #(
    .DEPTH_LOG (IQ_SIZE_LOG),
    .WIDTH     ($bits(iq_entry_t))
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_entry_s),
    .head  (head_data_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Next-state and next-PC selection
  always_comb begin
    state_n_s = state_r;
    pc_n_s    = pc_r;
    if (bus.rob_clear) begin
      pc_n_s    = bus.rob_redirect_pc;
      state_n_s = ST_RESTART;
    end else begin
      case (state_r)
        ST_REQ: begin
          if (hit_s) begin
`ifdef INS_FETCHER_JALR_STALL_EN
            if (is_jalr(bus.icache_ins)) begin
              state_n_s = ST_HOLD_JALR;
            end else begin
              pc_n_s = bus.pc_pred;
            end
`else
            pc_n_s = bus.pc_pred;
`endif
          end else begin
            state_n_s = ST_REQ;
          end
        end
        ST_RESTART: state_n_s = ST_REQ;
`ifdef INS_FETCHER_JALR_STALL_EN
        ST_HOLD_JALR: state_n_s = ST_HOLD_JALR;
`endif
        default: state_n_s = ST_REQ;
      endcase
    end
  end

  // State and PC registers; rst outranks rdy
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_REQ;
      pc_r    <= RESET_PC;
    end else if (rdy) begin
      state_r <= state_n_s;
      pc_r    <= pc_n_s;
    end else begin
      state_r <= state_r;
      pc_r    <= pc_r;
    end
  end

endmodule

// File: tb/tb_ins_fetcher.sv
// Directed self-checking bench for ins_fetcher with a simple ICache/predictor model.
module tb_ins_fetcher;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  int   checks = 0;
  int   errors = 0;

  logic        pred_en;
  logic [31:0] pred_target;
  logic        ins_ovr_en;
  logic [31:0] ins_ovr;

  ins_fetcher_if bus ();

  ins_fetcher #(.IQ_SIZE_LOG(4), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ins_for(input logic [31:0] a);
    return {a[24:0], 7'h13};
  endfunction

  assign bus.icache_ins = ins_ovr_en ? ins_ovr : ins_for(bus.fetch_addr);
  assign bus.pc_pred    = pred_en ? pred_target : bus.pc_cur + 32'd4;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    rdy = 1'b1;
    bus.icache_hit      = 1'b0;
    bus.dispatch_ready  = 1'b0;
    bus.rob_clear       = 1'b0;
    bus.rob_redirect_pc = 32'h0;
    bus.predict_jump    = 1'b0;
    pred_en     = 1'b0;
    pred_target = 32'h0;
    ins_ovr_en  = 1'b0;
    ins_ovr     = 32'h0;

    // reset
    tick();
    tick();
    chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("rst_ins_valid", 32'(bus.ins_valid), 32'd0);
    chk("rst_fetch_addr", bus.fetch_addr, 32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_fetch_valid", 32'(bus.fetch_valid), 32'd1);

    // streaming with 1-cycle lag
    bus.icache_hit     = 1'b1;
    bus.dispatch_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("stream_addr", bus.fetch_addr, 32'(4 * i));
      chk("stream_valid", 32'(bus.ins_valid), 32'd1);
      chk("stream_pc", bus.ins_pc, 32'(4 * (i - 1)));
      chk("stream_ins", bus.ins_out, ins_for(32'(4 * (i - 1))));
    end

    // rdy low freezes everything
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz_addr", bus.fetch_addr, 32'h18);
      chk("frz_pc", bus.ins_pc, 32'h14);
      chk("frz_valid", 32'(bus.ins_valid), 32'd1);
      chk("frz_fetch_valid", 32'(bus.fetch_valid), 32'd1);
    end
    rdy = 1'b1;
    tick();
    chk("resume_addr", bus.fetch_addr, 32'h1c);
    chk("resume_pc", bus.ins_pc, 32'h18);

    // fill the queue
    rst = 1'b1;
    tick();
    chk("rst2_ins_valid", 32'(bus.ins_valid), 32'd0);
    rst = 1'b0;
    bus.dispatch_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("fill15_fetch_valid", 32'(bus.fetch_valid), 32'd1);
    tick();
    chk("full_fetch_valid", 32'(bus.fetch_valid), 32'd0);
    chk("full_addr", bus.fetch_addr, 32'h40);
    chk("full_head_pc", bus.ins_pc, 32'h0);
    tick();
    chk("full_hold_fv", 32'(bus.fetch_valid), 32'd0);
    chk("full_hold_addr", bus.fetch_addr, 32'h40);
    bus.dispatch_ready = 1'b1;
    tick();
    bus.dispatch_ready = 1'b0;
    chk("after_pop_fv", 32'(bus.fetch_valid), 32'd1);
    chk("after_pop_head", bus.ins_pc, 32'h4);
    tick();
    chk("refull_fv", 32'(bus.fetch_valid), 32'd0);
    chk("refull_addr", bus.fetch_addr, 32'h44);
    bus.icache_hit     = 1'b0;
    bus.dispatch_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk("drain_pc", bus.ins_pc, 32'(4 * (j + 1)));
      chk("drain_ins", bus.ins_out, ins_for(32'(4 * (j + 1))));
      tick();
    end
    chk("drained_valid", 32'(bus.ins_valid), 32'd0);
    chk("drained_addr", bus.fetch_addr, 32'h44);

    // predicted-taken hit
    bus.dispatch_ready  = 1'b0;
    bus.rob_clear       = 1'b1;
    bus.rob_redirect_pc = 32'h10;
    tick();
    bus.rob_clear = 1'b0;
    chk("redir10_fv", 32'(bus.fetch_valid), 32'd0);
    chk("redir10_addr", bus.fetch_addr, 32'h10);
    tick();
    chk("redir10_fv_back", 32'(bus.fetch_valid), 32'd1);
    bus.icache_hit   = 1'b1;
    bus.predict_jump = 1'b1;
    pred_en          = 1'b1;
    pred_target      = 32'h100;
    tick();
    chk("jump_addr", bus.fetch_addr, 32'h100);
    chk("jump_head_pc", bus.ins_pc, 32'h10);
    chk("jump_head_pj", 32'(bus.ins_pred_jump), 32'd1);
    chk("jump_head_ins", bus.ins_out, ins_for(32'h10));
    bus.predict_jump = 1'b0;
    pred_en          = 1'b0;

    // flush with 5 entries and a same-cycle hit
    for (int i = 0; i < 4; i++) tick();
    chk("pre_flush_addr", bus.fetch_addr, 32'h110);
    bus.rob_clear       = 1'b1;
    bus.rob_redirect_pc = 32'h200;
    bus.dispatch_ready  = 1'b1;
    tick();
    bus.rob_clear = 1'b0;
    chk("flush_ins_valid", 32'(bus.ins_valid), 32'd0);
    chk("flush_fv", 32'(bus.fetch_valid), 32'd0);
    chk("flush_addr", bus.fetch_addr, 32'h200);
    tick();
    chk("bubble_ins_valid", 32'(bus.ins_valid), 32'd0);
    chk("bubble_fv", 32'(bus.fetch_valid), 32'd1);
    chk("bubble_addr", bus.fetch_addr, 32'h200);
    tick();
    chk("refetch_valid", 32'(bus.ins_valid), 32'd1);
    chk("refetch_pc", bus.ins_pc, 32'h200);
    chk("refetch_addr", bus.fetch_addr, 32'h204);

    // flush again while in RESTART
    bus.rob_clear       = 1'b1;
    bus.rob_redirect_pc = 32'h280;
    tick();
    chk("dbl1_fv", 32'(bus.fetch_valid), 32'd0);
    chk("dbl1_addr", bus.fetch_addr, 32'h280);
    bus.rob_redirect_pc = 32'h2c0;
    tick();
    bus.rob_clear = 1'b0;
    chk("dbl2_fv", 32'(bus.fetch_valid), 32'd0);
    chk("dbl2_addr", bus.fetch_addr, 32'h2c0);
    tick();
    chk("dbl3_fv", 32'(bus.fetch_valid), 32'd1);
    chk("dbl3_addr", bus.fetch_addr, 32'h2c0);
    chk("dbl3_ins_valid", 32'(bus.ins_valid), 32'd0);
    tick();
    chk("dbl4_ins_valid", 32'(bus.ins_valid), 32'd1);
    chk("dbl4_pc", bus.ins_pc, 32'h2c0);
    chk("dbl4_addr", bus.fetch_addr, 32'h2c4);

    // JALR word at 0x20
    bus.dispatch_ready  = 1'b0;
    bus.rob_clear       = 1'b1;
    bus.rob_redirect_pc = 32'h20;
    tick();
    bus.rob_clear = 1'b0;
    tick();
    ins_ovr_en       = 1'b1;
    ins_ovr          = 32'h000080E7;
    bus.predict_jump = 1'b1;
    tick();
`ifdef INS_FETCHER_JALR_STALL_EN
    chk("jalr_fv", 32'(bus.fetch_valid), 32'd0);
    chk("jalr_addr", bus.fetch_addr, 32'h20);
    chk("jalr_pc", bus.ins_pc, 32'h20);
    chk("jalr_ins", bus.ins_out, 32'h000080E7);
    chk("jalr_pj", 32'(bus.ins_pred_jump), 32'd0);
    ins_ovr_en       = 1'b0;
    bus.predict_jump = 1'b0;
    tick();
    tick();
    chk("jalr_hold_fv", 32'(bus.fetch_valid), 32'd0);
    chk("jalr_hold_addr", bus.fetch_addr, 32'h20);
    bus.rob_clear       = 1'b1;
    bus.rob_redirect_pc = 32'h300;
    tick();
    bus.rob_clear = 1'b0;
    chk("jalr_flush_fv", 32'(bus.fetch_valid), 32'd0);
    chk("jalr_flush_addr", bus.fetch_addr, 32'h300);
    chk("jalr_flush_valid", 32'(bus.ins_valid), 32'd0);
    tick();
    chk("jalr_resume_fv", 32'(bus.fetch_valid), 32'd1);
    chk("jalr_resume_addr", bus.fetch_addr, 32'h300);
`else
    chk("jalr_fv", 32'(bus.fetch_valid), 32'd1);
    chk("jalr_addr", bus.fetch_addr, 32'h24);
    chk("jalr_pc", bus.ins_pc, 32'h20);
    chk("jalr_ins", bus.ins_out, 32'h000080E7);
    chk("jalr_pj", 32'(bus.ins_pred_jump), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
